// File: rtl/z80bus_pkg.sv
// Shared types for the tv80s bus memory/I-O responder: access kinds, FSM states,
// trace entry layout and the bus-cycle classifier.
package z80bus_pkg;

  localparam int WAIT_W = 3;

  typedef enum logic [2:0] {
    NONE,
    MEM_RD,
    MEM_WR,
    IO_RD,
    IO_WR,
    INTA,
    RFSH
  } acc_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_e;

  typedef struct packed {
    logic        io;
    logic [15:0] addr;
    logic [7:0]  data;
  } trace_entry_t;

  // Refresh and interrupt-acknowledge take priority over the plain read/write decode.
  function automatic acc_e classify(input logic m1_n, input logic mreq_n,
                                    input logic iorq_n, input logic rd_n,
                                    input logic wr_n, input logic rfsh_n);
    acc_e k;
    k = NONE;
    if (!mreq_n && !rfsh_n)                 k = RFSH;
    else if (!mreq_n && (!rd_n || !wr_n))   k = wr_n ? MEM_RD : MEM_WR;
    else if (!iorq_n && !m1_n)              k = INTA;
    else if (!iorq_n && (!rd_n || !wr_n))   k = wr_n ? IO_RD : IO_WR;
    return k;
  endfunction

endpackage

// File: rtl/z80bus_trace_fifo.sv
// Bus-write trace FIFO: push with full flag in, valid/ready out, sticky overflow.
// DEPTH must be a power of two, at least 2.
module z80bus_trace_fifo
  import z80bus_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         push_i,
  input  trace_entry_t push_data_i,
  output logic         full_o,
  output logic         valid_o,
  input  logic         ready_i,
  output trace_entry_t data_o,
  output logic         overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             overflow_q;
  trace_entry_t     buf_q [DEPTH];

  logic empty, pop, push_ok;

  assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign valid_o    = !empty;
  assign data_o     = buf_q[rd_ptr_q];
  assign overflow_o = overflow_q;
  assign pop        = ready_i && !empty;
  // A pop frees the slot this cycle, so a push into a full FIFO is still taken.
  assign push_ok    = push_i && (!full_o || pop);

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
      if (push_i && !push_ok) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) buf_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/z80_bus_mem.sv
// Clocked memory and I/O responder for the tv80s bus with wait states and backdoor preload.
// Optional write-trace FIFO built when Z80BUS_TRACE_EN is defined.
module z80_bus_mem
  import z80bus_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int IO_W        = 8,
  parameter int MEM_WAIT    = 0,
  parameter int IO_WAIT     = 1,
  parameter int TRACE_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_di,
  output logic        wait_n,
  input  logic        bd_we,
  input  logic        bd_io,
  input  logic [15:0] bd_addr,
  input  logic [7:0]  bd_data,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [24:0] trace_data,
  output logic        trace_overflow
);

  localparam logic [WAIT_W-1:0] MEM_N = WAIT_W'(MEM_WAIT);
  localparam logic [WAIT_W-1:0] IO_N  = WAIT_W'(IO_WAIT);

  acc_e              kind, kind_q;
  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d, n_sel;
  logic [15:0]       addr_q;
  logic              wr_done_q, done_eff;
  logic              is_mem, is_io, is_acc, is_wr, new_acc, wait_req, commit;
  logic [7:0]        cpu_di_q, rd_data;
  logic [7:0]        mem_q [2**ADDR_W];
  logic [7:0]        io_q  [2**IO_W];

  assign kind   = classify(m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n);
  assign is_mem = (kind == MEM_RD) || (kind == MEM_WR);
  assign is_io  = (kind == IO_RD)  || (kind == IO_WR);
  assign is_acc = is_mem || is_io;
  assign is_wr  = (kind == MEM_WR) || (kind == IO_WR);
  assign n_sel  = is_mem ? MEM_N : IO_N;

  // A change of kind or address while holding is a back-to-back access.
  assign new_acc = is_acc && ((state_q == IDLE) ||
                   ((state_q == HOLD) && ((kind != kind_q) || (A != addr_q))));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_req = 1'b0;
    case (state_q)
      IDLE, HOLD: begin
        if (new_acc) begin
          if (n_sel != '0) begin
            state_d  = WAIT;
            cnt_d    = n_sel - WAIT_W'(1);
            wait_req = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end else if (!is_acc) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
        end else begin
          cnt_d    = cnt_q - WAIT_W'(1);
          wait_req = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset drops any write still waiting out its wait states.
  assign done_eff = new_acc ? 1'b0 : wr_done_q;
  assign commit   = reset_n && is_wr && !wait_req && !done_eff;
  assign wait_n   = reset_n ? !wait_req : 1'b1;

  always_comb begin
    rd_data = mem_q[A[ADDR_W-1:0]];
    if (kind == INTA)  rd_data = 8'hFF;
    else if (is_io)    rd_data = io_q[A[IO_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      kind_q    <= NONE;
      addr_q    <= '0;
      wr_done_q <= 1'b0;
      cpu_di_q  <= 8'hFF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_done_q <= done_eff | commit;
      cpu_di_q  <= rd_data;
      if (new_acc) begin
        kind_q <= kind;
        addr_q <= A;
      end
    end
  end

  assign cpu_di = cpu_di_q;

  // Bus write is issued after the backdoor so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (bd_we) begin
      if (bd_io) io_q[bd_addr[IO_W-1:0]]    <= bd_data;
      else       mem_q[bd_addr[ADDR_W-1:0]] <= bd_data;
    end
    if (commit) begin
      if (is_io) io_q[A[IO_W-1:0]]    <= cpu_dout;
      else       mem_q[A[ADDR_W-1:0]] <= cpu_dout;
    end
  end

  logic unused_addr;
  assign unused_addr = ^{A, bd_addr};

`ifdef Z80BUS_TRACE_EN
  trace_entry_t push_entry, pop_entry;
  logic         trace_full;
  logic         unused_trace;

  assign push_entry = '{io: is_io, addr: A, data: cpu_dout};

  z80bus_trace_fifo #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .push_i      (commit),
    .push_data_i (push_entry),
    .full_o      (trace_full),
    .valid_o     (trace_valid),
    .ready_i     (trace_ready),
    .data_o      (pop_entry),
    .overflow_o  (trace_overflow)
  );

  assign trace_data   = pop_entry;
  assign unused_trace = trace_full;
`else
  logic unused_trace;

  assign trace_valid    = 1'b0;
  assign trace_data     = '0;
  assign trace_overflow = 1'b0;
  assign unused_trace   = trace_ready ^ (TRACE_DEPTH > 1);
`endif

endmodule

// File: tb/tb_z80_bus_mem.sv
// Directed bench for z80_bus_mem: two instances (zero and two memory wait states)
// share one emulated tv80s bus; trace checks follow the Z80BUS_TRACE_EN build.
module tb_z80_bus_mem;

  localparam logic [5:0] S_IDLE  = 6'b111111;
  localparam logic [5:0] S_FETCH = 6'b001011;
  localparam logic [5:0] S_RFSH  = 6'b101110;
  localparam logic [5:0] S_MREQ  = 6'b101111;
  localparam logic [5:0] S_MWR   = 6'b101101;
  localparam logic [5:0] S_IOWR  = 6'b110101;
  localparam logic [5:0] S_IORD  = 6'b110011;
  localparam logic [5:0] S_INTA  = 6'b010111;

  logic        clk = 1'b0;
  logic        reset_n, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic        bd_we, bd_io, trace_ready;
  logic [15:0] a, bd_addr;
  logic [7:0]  cpu_dout, bd_data;

  logic [7:0]  cpu_di0, cpu_di2;
  logic        wait_n0, wait_n2, tv0, tv2, tov0, tov2;
  logic [24:0] td0, td2;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  z80_bus_mem #(.ADDR_W(16), .IO_W(8), .MEM_WAIT(0), .IO_WAIT(1), .TRACE_DEPTH(4)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .A(a), .cpu_dout(cpu_dout),
    .cpu_di(cpu_di0), .wait_n(wait_n0), .bd_we(bd_we), .bd_io(bd_io),
    .bd_addr(bd_addr), .bd_data(bd_data), .trace_valid(tv0),
    .trace_ready(trace_ready), .trace_data(td0), .trace_overflow(tov0)
  );

  z80_bus_mem #(.ADDR_W(16), .IO_W(8), .MEM_WAIT(2), .IO_WAIT(0), .TRACE_DEPTH(4)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .A(a), .cpu_dout(cpu_dout),
    .cpu_di(cpu_di2), .wait_n(wait_n2), .bd_we(bd_we), .bd_io(bd_io),
    .bd_addr(bd_addr), .bd_data(bd_data), .trace_valid(tv2),
    .trace_ready(trace_ready), .trace_data(td2), .trace_overflow(tov2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [5:0] s, input logic [15:0] addr, input logic [7:0] d);
    {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} = s;
    a        = addr;
    cpu_dout = d;
    #1;
  endtask

  // T1 address phase, then wr_n low long enough for two wait states, then release.
  task automatic mem_write(input logic [15:0] addr, input logic [7:0] d);
    bus(S_MREQ, addr, d);
    tick;
    bus(S_MWR, addr, d);
    tick;
    tick;
    tick;
    bus(S_IDLE, addr, d);
    tick;
  endtask

  function automatic logic [31:0] tent(input logic io, input logic [15:0] ad, input logic [7:0] d);
    return {7'd0, io, ad, d};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; bd_we = 1'b0; bd_io = 1'b0; bd_addr = '0; bd_data = '0;
    trace_ready = 1'b0;
    bus(S_IDLE, 16'h0000, 8'h00);
    tick;
    tick;
    chk("rst_cpu_di0", 32'(cpu_di0), 32'hFF);
    chk("rst_cpu_di2", 32'(cpu_di2), 32'hFF);
    chk("rst_wait0", 32'(wait_n0), 32'd1);
    chk("rst_tv0", 32'(tv0), 32'd0);
    chk("rst_tov0", 32'(tov0), 32'd0);
    reset_n = 1'b1;
    tick;

    bd_we = 1'b1; bd_io = 1'b0; bd_addr = 16'h0000; bd_data = 8'hC8;
    tick;
    bd_addr = 16'h43F7; bd_data = 8'hE9;
    tick;
    bd_io = 1'b1; bd_addr = 16'h0033; bd_data = 8'h99;
    tick;
    bd_we = 1'b0; bd_io = 1'b0;

    bus(S_FETCH, 16'h0000, 8'h00);
    chk("fetch_w0_c0", 32'(wait_n0), 32'd1);
    chk("fetch_w2_c0", 32'(wait_n2), 32'd0);
    tick;
    chk("fetch_di0", 32'(cpu_di0), 32'hC8);
    chk("fetch_di2", 32'(cpu_di2), 32'hC8);
    chk("fetch_w2_c1", 32'(wait_n2), 32'd0);
    tick;
    chk("fetch_w2_c2", 32'(wait_n2), 32'd1);
    tick;
    chk("fetch_w2_c3", 32'(wait_n2), 32'd1);

    bus(S_RFSH, 16'h43F7, 8'h00);
    chk("rfsh_w0", 32'(wait_n0), 32'd1);
    chk("rfsh_w2", 32'(wait_n2), 32'd1);
    tick;
    chk("rfsh_track_di", 32'(cpu_di0), 32'hE9);
    bus(S_IDLE, 16'h43F7, 8'h00);
    tick;
    chk("rfsh_no_trace", 32'(tv0), 32'd0);

    bus(S_IORD, 16'h0033, 8'h00);
    chk("in_w0_c0", 32'(wait_n0), 32'd0);
    chk("in_w2_c0", 32'(wait_n2), 32'd1);
    tick;
    chk("in_bd_di0", 32'(cpu_di0), 32'h99);
    chk("in_w0_c1", 32'(wait_n0), 32'd1);
    bus(S_IDLE, 16'h1234, 8'h00);
    tick;

    mem_write(16'h1234, 8'h3C);
    chk("mwr_rd_di0", 32'(cpu_di0), 32'h3C);
    chk("mwr_rd_di2", 32'(cpu_di2), 32'h3C);
`ifdef Z80BUS_TRACE_EN
    chk("mwr_tv0", 32'(tv0), 32'd1);
    chk("mwr_td0", 32'(td0), tent(1'b0, 16'h1234, 8'h3C));
    chk("mwr_tv2", 32'(tv2), 32'd1);
    chk("mwr_td2", 32'(td2), tent(1'b0, 16'h1234, 8'h3C));
    trace_ready = 1'b1;
    tick;
    trace_ready = 1'b0;
    chk("mwr_once_tv0", 32'(tv0), 32'd0);
    chk("mwr_once_tv2", 32'(tv2), 32'd0);
`else
    chk("off_tv0", 32'(tv0), 32'd0);
    chk("off_td0", 32'(td0), 32'd0);
    chk("off_tov0", 32'(tov0), 32'd0);
`endif

    bus(S_IOWR, 16'h5A7F, 8'h5A);
    chk("out_w0_c0", 32'(wait_n0), 32'd0);
    chk("out_w2_c0", 32'(wait_n2), 32'd1);
    tick;
    chk("out_w0_c1", 32'(wait_n0), 32'd1);
    tick;
    bus(S_IDLE, 16'h007F, 8'h00);
    tick;
    bus(S_IORD, 16'h007F, 8'h00);
    tick;
    chk("out_io_di0", 32'(cpu_di0), 32'h5A);
    chk("out_io_di2", 32'(cpu_di2), 32'h5A);
    bus(S_IDLE, 16'h0000, 8'h00);
    tick;
`ifdef Z80BUS_TRACE_EN
    chk("out_tv0", 32'(tv0), 32'd1);
    chk("out_td0", 32'(td0), tent(1'b1, 16'h5A7F, 8'h5A));
    chk("out_td2", 32'(td2), tent(1'b1, 16'h5A7F, 8'h5A));
    trace_ready = 1'b1;
    tick;
    trace_ready = 1'b0;
    chk("out_once_tv0", 32'(tv0), 32'd0);
`endif

    bus(S_INTA, 16'h0000, 8'h00);
    chk("inta_w0", 32'(wait_n0), 32'd1);
    chk("inta_w2", 32'(wait_n2), 32'd1);
    tick;
    chk("inta_di0", 32'(cpu_di0), 32'hFF);
    bus(S_IDLE, 16'h0000, 8'h00);
    tick;
    chk("idle_track_di0", 32'(cpu_di0), 32'hC8);

    bus(S_MREQ, 16'h2000, 8'h22);
    tick;
    bd_we = 1'b1; bd_io = 1'b0; bd_addr = 16'h2000; bd_data = 8'h11;
    bus(S_MWR, 16'h2000, 8'h22);
    tick;
    bd_we = 1'b0;
    tick;
    tick;
    bus(S_IDLE, 16'h2000, 8'h00);
    tick;
    chk("bd_collide_di0", 32'(cpu_di0), 32'h22);

    trace_ready = 1'b1;
    repeat (6) tick;
    trace_ready = 1'b0;

    for (int i = 0; i < 6; i++) begin
      mem_write(16'h3000 + 16'(i), 8'hA0 + 8'(i));
      if (i == 3) chk("ovf_not_yet_tov0", 32'(tov0), 32'd0);
    end
`ifdef Z80BUS_TRACE_EN
    chk("ovf_tov0", 32'(tov0), 32'd1);
    chk("ovf_tov2", 32'(tov2), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_td0", 32'(td0), tent(1'b0, 16'h3000 + 16'(i), 8'hA0 + 8'(i)));
      chk("ovf_td2", 32'(td2), tent(1'b0, 16'h3000 + 16'(i), 8'hA0 + 8'(i)));
      trace_ready = 1'b1;
      tick;
      trace_ready = 1'b0;
    end
    chk("ovf_drained_tv0", 32'(tv0), 32'd0);
    chk("ovf_sticky_tov0", 32'(tov0), 32'd1);
    mem_write(16'h3010, 8'h5C);
`else
    chk("off_ovf_tov0", 32'(tov0), 32'd0);
    chk("off_ovf_tv2", 32'(tv2), 32'd0);
`endif

    bus(S_IDLE, 16'h3003, 8'h00);
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
    chk("rst2_tov0", 32'(tov0), 32'd0);
    chk("rst2_tv0", 32'(tv0), 32'd0);
    chk("rst2_tv2", 32'(tv2), 32'd0);
    chk("rst2_mem_kept0", 32'(cpu_di0), 32'hA3);
    chk("rst2_mem_kept2", 32'(cpu_di2), 32'hA3);

    bd_we = 1'b1; bd_io = 1'b0; bd_addr = 16'h4000; bd_data = 8'h55;
    tick;
    bd_we = 1'b0;
    bus(S_MREQ, 16'h4000, 8'h77);
    tick;
    bus(S_MWR, 16'h4000, 8'h77);
    chk("rstw_w2_c0", 32'(wait_n2), 32'd0);
    tick;
    chk("rstw_w2_c1", 32'(wait_n2), 32'd0);
    reset_n = 1'b0;
    #1;
    tick;
    chk("rstw_w2_after", 32'(wait_n2), 32'd1);
    bus(S_IDLE, 16'h4000, 8'h00);
    reset_n = 1'b1;
    tick;
    tick;
    chk("rstw_no_update2", 32'(cpu_di2), 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
